// File: rtl/pwm_ramp_ctrl.sv
// Soft-start/soft-stop sequencer: walks the applied PWM speed one code per STEP_DIV clocks.
// Optional feature macro: PWM_RAMP_KILL_EN adds a `kill` input that forces IDLE immediately.
module pwm_ramp_ctrl #(
  parameter int STEP_DIV = 1024,
  parameter int SPEED_W  = 3
) (
  input  logic               clk,
  input  logic               rst,
`ifdef PWM_RAMP_KILL_EN
  input  logic               kill,
`endif
  input  logic               enable_in,
  input  logic [SPEED_W-1:0] target,
  output logic [SPEED_W-1:0] speed_out,
  output logic               pwm_en,
  output logic               busy,
  output logic               at_target
);

  localparam int CW = $clog2(STEP_DIV);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RAMP = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_STOP = 2'd3;

  localparam logic [CW-1:0]      CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]      CNT_LAST = CW'(STEP_DIV - 1);
  localparam logic [SPEED_W-1:0] SPD_ZERO = {SPEED_W{1'b0}};
  localparam logic [SPEED_W-1:0] SPD_ONE  = SPEED_W'(1);

  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [SPEED_W-1:0] r_speed;
  logic               r_pwm_en;
  logic               r_busy;
  logic               r_at_target;

  logic               w_step;
  logic [SPEED_W-1:0] w_speed_ramp;
  logic [SPEED_W-1:0] w_speed_dec;
  logic [1:0]         w_state_nrm;
  logic [CW-1:0]      w_cnt_nrm;
  logic [SPEED_W-1:0] w_speed_nrm;
  logic [1:0]         w_state_nxt;
  logic [CW-1:0]      w_cnt_nxt;
  logic [SPEED_W-1:0] w_speed_nxt;

  assign w_step       = (r_cnt == CNT_LAST);
  assign w_speed_ramp = (target > r_speed) ? (r_speed + SPD_ONE) : (r_speed - SPD_ONE);
  assign w_speed_dec  = r_speed - SPD_ONE;

  // Next-state, step-counter and speed decode; every state change clears the counter.
  always_comb begin
    w_state_nrm = r_state;
    w_cnt_nrm   = r_cnt;
    w_speed_nrm = r_speed;
    case (r_state)
      S_IDLE: begin
        w_speed_nrm = SPD_ZERO;
        w_cnt_nrm   = CNT_ZERO;
        if (enable_in) begin
          w_state_nrm = (target == SPD_ZERO) ? S_HOLD : S_RAMP;
        end else begin
          w_state_nrm = S_IDLE;
        end
      end
      S_RAMP: begin
        if (!enable_in) begin
          w_state_nrm = S_STOP;
          w_cnt_nrm   = CNT_ZERO;
        end else if (r_speed == target) begin
          w_state_nrm = S_HOLD;
          w_cnt_nrm   = CNT_ZERO;
        end else if (w_step) begin
          w_speed_nrm = w_speed_ramp;
          w_cnt_nrm   = CNT_ZERO;
          w_state_nrm = (w_speed_ramp == target) ? S_HOLD : S_RAMP;
        end else begin
          w_cnt_nrm   = r_cnt + CNT_ONE;
        end
      end
      S_HOLD: begin
        if (!enable_in) begin
          w_state_nrm = S_STOP;
          w_cnt_nrm   = CNT_ZERO;
        end else if (target != r_speed) begin
          w_state_nrm = S_RAMP;
          w_cnt_nrm   = CNT_ZERO;
        end else begin
          w_state_nrm = S_HOLD;
        end
      end
      S_STOP: begin
        if (enable_in) begin
          w_state_nrm = S_RAMP;
          w_cnt_nrm   = CNT_ZERO;
        end else if (r_speed == SPD_ZERO) begin
          w_state_nrm = S_IDLE;
          w_cnt_nrm   = CNT_ZERO;
        end else if (w_step) begin
          w_speed_nrm = w_speed_dec;
          w_cnt_nrm   = CNT_ZERO;
          w_state_nrm = (w_speed_dec == SPD_ZERO) ? S_IDLE : S_STOP;
        end else begin
          w_cnt_nrm   = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nrm = S_IDLE;
        w_cnt_nrm   = CNT_ZERO;
        w_speed_nrm = SPD_ZERO;
      end
    endcase
  end

`ifdef PWM_RAMP_KILL_EN
  // Emergency kill overrides the normal sequencing and parks the block in IDLE.
  always_comb begin
    if (kill) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = CNT_ZERO;
      w_speed_nxt = SPD_ZERO;
    end else begin
      w_state_nxt = w_state_nrm;
      w_cnt_nxt   = w_cnt_nrm;
      w_speed_nxt = w_speed_nrm;
    end
  end
`else
  assign w_state_nxt = w_state_nrm;
  assign w_cnt_nxt   = w_cnt_nrm;
  assign w_speed_nxt = w_speed_nrm;
`endif

  // State, counter and flag registers; flags decode from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= CNT_ZERO;
      r_speed     <= SPD_ZERO;
      r_pwm_en    <= 1'b0;
      r_busy      <= 1'b0;
      r_at_target <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_speed     <= w_speed_nxt;
      r_pwm_en    <= (w_state_nxt != S_IDLE);
      r_busy      <= (w_state_nxt == S_RAMP) || (w_state_nxt == S_STOP);
      r_at_target <= (w_state_nxt == S_HOLD);
    end
  end

  assign speed_out = r_speed;
  assign pwm_en    = r_pwm_en;
  assign busy      = r_busy;
  assign at_target = r_at_target;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: directed soft-start/stop timeline plus randomized run vs a behavioural model.
module tb_pwm_ramp_ctrl;

  localparam int SD = 4;
  localparam int SW = 3;

  localparam int MODE_OFF  = 0;
  localparam int MODE_MOVE = 1;
  localparam int MODE_AT   = 2;
  localparam int MODE_DOWN = 3;

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic          enable_in = 1'b0;
  logic          kill_s    = 1'b0;
  logic [SW-1:0] target    = 3'd0;
  logic [SW-1:0] speed_out;
  logic          pwm_en;
  logic          busy;
  logic          at_target;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // Model: whether PWM is on, current speed, what it is doing, clocks spent in the current ramp.
  bit m_on    = 1'b0;
  int m_speed = 0;
  int m_mode  = MODE_OFF;
  int m_age   = 0;

  pwm_ramp_ctrl #(.STEP_DIV(SD), .SPEED_W(SW)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef PWM_RAMP_KILL_EN
    .kill      (kill_s),
`endif
    .enable_in (enable_in),
    .target    (target),
    .speed_out (speed_out),
    .pwm_en    (pwm_en),
    .busy      (busy),
    .at_target (at_target)
  );

  always #5 clk = ~clk;

  task automatic go_off();
    m_on    = 1'b0;
    m_speed = 0;
    m_mode  = MODE_OFF;
    m_age   = 0;
  endtask

  // One clock of the reference behaviour: a ramp moves one code every SD clocks of its age.
  task automatic model_step();
    if (rst || kill_s) begin
      go_off();
    end else if (!m_on) begin
      if (enable_in) begin
        m_on   = 1'b1;
        m_age  = 0;
        m_mode = (int'(target) == 0) ? MODE_AT : MODE_MOVE;
      end
    end else if (!enable_in) begin
      if (m_mode != MODE_DOWN) begin
        m_mode = MODE_DOWN;
        m_age  = 0;
      end else if (m_speed == 0) begin
        go_off();
      end else begin
        m_age++;
        if (m_age % SD == 0) begin
          m_speed--;
          if (m_speed == 0) go_off();
        end
      end
    end else if (m_mode == MODE_DOWN) begin
      m_mode = MODE_MOVE;
      m_age  = 0;
    end else if (m_mode == MODE_AT) begin
      if (int'(target) != m_speed) begin
        m_mode = MODE_MOVE;
        m_age  = 0;
      end
    end else if (int'(target) == m_speed) begin
      m_mode = MODE_AT;
    end else begin
      m_age++;
      if (m_age % SD == 0) begin
        m_speed += (int'(target) > m_speed) ? 1 : -1;
        if (m_speed == int'(target)) m_mode = MODE_AT;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      n_checks++;
      if (speed_out !== SW'(m_speed) || pwm_en !== m_on ||
          busy !== (m_mode == MODE_MOVE || m_mode == MODE_DOWN) ||
          at_target !== (m_mode == MODE_AT)) begin
        n_errors++;
        $display("FAIL cycle_cmp t=%0t: dut speed=%0d en=%b busy=%b at=%b, model speed=%0d en=%b mode=%0d",
                 $time, speed_out, pwm_en, busy, at_target, m_speed, m_on, m_mode);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t: got %0d expected %0d", nm, $time, got, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Flags packed as {pwm_en, busy, at_target}.
  initial begin
    rst = 1'b1;
    wait_n(3);
    chk_en = 1'b1;
    rst    = 1'b0;
    wait_n(20);
    chk("idle_speed", 32'(speed_out), 32'd0);
    chk("idle_flags", 32'({pwm_en, busy, at_target}), 32'd0);

    // Soft start to 5: speed k at edge 1+4k, HOLD at edge 21.
    target    = 3'd5;
    enable_in = 1'b1;
    wait_n(1);
    chk("start_flags", 32'({pwm_en, busy, at_target}), 32'b110);
    chk("start_speed", 32'(speed_out), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      wait_n(SD);
      chk("up_speed", 32'(speed_out), 32'(k));
    end
    chk("up_hold_flags", 32'({pwm_en, busy, at_target}), 32'b101);
    chk("model_up_speed", 32'(m_speed), 32'd5);

    // Ramp down toward 2, reversed toward 6 at speed 3.
    target = 3'd2;
    wait_n(1 + SD);
    chk("down_speed4", 32'(speed_out), 32'd4);
    wait_n(SD);
    chk("down_speed3", 32'(speed_out), 32'd3);
    target = 3'd6;
    for (int k = 4; k <= 6; k++) begin
      wait_n(SD);
      chk("rev_speed", 32'(speed_out), 32'(k));
    end
    chk("rev_hold_flags", 32'({pwm_en, busy, at_target}), 32'b101);

    // Down to HOLD at 3, then stop, re-enable at speed 1, then full stop.
    target = 3'd3;
    wait_n(1 + 3 * SD);
    chk("hold3_speed", 32'(speed_out), 32'd3);
    chk("hold3_flags", 32'({pwm_en, busy, at_target}), 32'b101);
    enable_in = 1'b0;
    wait_n(1 + SD);
    chk("stop_speed2", 32'(speed_out), 32'd2);
    wait_n(SD);
    chk("stop_speed1", 32'(speed_out), 32'd1);
    enable_in = 1'b1;
    wait_n(1 + SD);
    chk("reen_speed2", 32'(speed_out), 32'd2);
    wait_n(SD);
    chk("reen_speed3", 32'(speed_out), 32'd3);
    chk("reen_flags", 32'({pwm_en, busy, at_target}), 32'b101);
    enable_in = 1'b0;
    wait_n(3 * SD);
    chk("stop_last_flags", 32'({pwm_en, busy, at_target}), 32'b110);
    chk("stop_last_speed", 32'(speed_out), 32'd1);
    wait_n(1);
    chk("stop_done_flags", 32'({pwm_en, busy, at_target}), 32'b000);
    chk("stop_done_speed", 32'(speed_out), 32'd0);
    chk("model_stop_on", 32'(m_on), 32'd0);

    // Reset in the middle of a ramp at speed 4.
    target    = 3'd7;
    enable_in = 1'b1;
    wait_n(1 + 4 * SD);
    chk("pre_rst_speed", 32'(speed_out), 32'd4);
    rst = 1'b1;
    wait_n(1);
    chk("rst_speed", 32'(speed_out), 32'd0);
    chk("rst_flags", 32'({pwm_en, busy, at_target}), 32'b000);
    enable_in = 1'b0;
    wait_n(1);
    rst = 1'b0;

    // Start with target 0 goes straight to HOLD; disabling drops pwm_en two edges later.
    target    = 3'd0;
    enable_in = 1'b1;
    wait_n(1);
    chk("zero_hold_flags", 32'({pwm_en, busy, at_target}), 32'b101);
    enable_in = 1'b0;
    wait_n(1);
    chk("zero_stop_flags", 32'({pwm_en, busy, at_target}), 32'b110);
    wait_n(1);
    chk("zero_idle_flags", 32'({pwm_en, busy, at_target}), 32'b000);

    // Randomized run checked cycle by cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(39, 0) == 0) enable_in = ~enable_in;
      if ($urandom_range(24, 0) == 0) target = SW'($urandom_range(7, 0));
      rst = ($urandom_range(599, 0) == 0);
`ifdef PWM_RAMP_KILL_EN
      kill_s = ($urandom_range(299, 0) == 0) ? 1'b1 : (kill_s & ($urandom_range(3, 0) != 0));
`endif
      wait_n(1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pwm_ramp_ctrl.md
# pwm_ramp_ctrl

Soft-start/soft-stop sequencer for the PWM generator. It sits between the user inputs (enable and a 3-bit speed request) and the PWM block's `enable`/`speed` inputs. It never lets the applied speed jump: the speed moves one code at a time, once every `STEP_DIV` clocks, toward the requested value. On disable it ramps down to zero before dropping the PWM enable.

## Interface
- `STEP_DIV`, default 1024: clocks per ramp step; legal range ≥ 2.
- `SPEED_W`, default 3: width of speed codes.

Ports:
- `clk`  in  1: single system clock; all logic on the rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `enable_in`  in  1: run request; level-sensitive.
- `target`  in  `SPEED_W`: requested speed code; sampled every cycle.
- `speed_out`  out  `SPEED_W`: speed code applied to the PWM generator.
- `pwm_en`  out  1: enable to the PWM generator.
- `busy`  out  1: high while ramping (RAMP or STOP).
- `at_target`  out  1: high in HOLD.
- `kill`  in  1: present only with `PWM_RAMP_KILL_EN`.

## Operation
- Every output and every internal register is driven from a flop.
- Reset values: `speed_out`=0, `pwm_en`=0, `busy`=0, `at_target`=0, state=IDLE, step counter=0.
- Step counter:
  - Width is `$clog2(STEP_DIV)`.
  - Cleared on every state entry.
  - Counts only in RAMP and STOP.
  - `step` is true when the counter equals `STEP_DIV-1`; the counter then wraps to 0.
- IDLE:
  - `pwm_en`=0, `speed_out`=0.
  - `enable_in`=1 goes to RAMP, or to HOLD if `target`==0.
- RAMP:
  - `pwm_en`=1.
  - On `step`: `speed_out` ±1 toward `target`. Direction is re-evaluated at every step, so a `target` change mid-ramp reverses the ramp cleanly.
  - If the updated speed equals `target`, go to HOLD on the same edge.
  - If `speed_out`==`target` without a step (target moved onto the current value), go to HOLD next edge.
  - `enable_in`=0 goes to STOP.
- HOLD:
  - `speed_out` is constant.
  - `target`≠`speed_out` goes to RAMP.
  - `enable_in`=0 goes to STOP.
- STOP:
  - `pwm_en` stays 1.
  - On `step`: `speed_out` −1.
  - When `speed_out` is 0 (on entry, or after a decrement), go to IDLE. `pwm_en` falls on that same edge.
  - `enable_in`=1 goes to RAMP; the counter is cleared.
- Priority, highest first: `rst` > `kill` > `enable_in`=0 > target comparison.
- Arithmetic: unsigned `SPEED_W`-bit values. The ramp never passes `target`, so no wrap is possible; 0 and 2^`SPEED_W`−1 are never exceeded.

## Timing
- `enable_in` rises in IDLE with `target`=T>0:
  - `pwm_en`=1 and `busy`=1 on the next edge.
  - `speed_out` reaches k at `1+k*STEP_DIV` edges after the sample.
  - HOLD (`at_target`=1, `busy`=0) is entered on the edge where `speed_out` becomes T.
- `enable_in` falls in HOLD at speed S:
  - `speed_out` reaches 0 and `pwm_en` drops `1+S*STEP_DIV` edges after the sample.
  - With S=0, `pwm_en` drops 2 edges after the sample (HOLD→STOP→IDLE).
- Synchronous `rst` mid-ramp: all outputs take their reset values on the next edge, with no ramp-down.
- `busy` and `at_target` are mutually exclusive; both are 0 in IDLE.

## Configuration
- `PWM_RAMP_KILL_EN` defined:
  - Adds the `kill` input.
  - `kill`=1 forces state=IDLE, `speed_out`=0, `pwm_en`=0 on the next edge, from any state.
  - IDLE is held while `kill`=1.
  - After `kill` falls, normal IDLE rules apply.
- `PWM_RAMP_KILL_EN` undefined: no port and no logic. Only `enable_in` stops the PWM, always via the STOP ramp.

## Test plan
Run all scenarios with `STEP_DIV`=4, `SPEED_W`=3.
- Reset release, `enable_in`=0 for 20 cycles → all outputs 0, state IDLE.
- `enable_in`=1, `target`=5 → `pwm_en`=1 after 1 edge; `speed_out` steps 1,2,3,4,5 every 4 clocks; `at_target`=1 at edge 21; `busy`=0 from then on.
- In HOLD at 5, `target`→2 → `speed_out` 4,3,2 at 4-clock spacing, then HOLD. Mid-ramp at 3, `target`→6 → `speed_out` 4,5,6 with no overshoot below 3.
- In HOLD at 3, `enable_in`=0 → `speed_out` 2,1,0 at 4-clock spacing; `pwm_en` falls with the 0 edge (edge 13). `enable_in`=1 during STOP at speed 1 → returns to RAMP; counter restarts.
- `rst`=1 during RAMP at speed 4 → next edge: `speed_out`=0, `pwm_en`=0, `busy`=0.
- With `PWM_RAMP_KILL_EN`: HOLD at 7, `kill`=1 → next edge all outputs 0; held while `kill`=1 and `enable_in`=1; `kill`=0 → ramp restarts from 0.
